bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bin2bcd_seq.sv | 86 ++++++++
 tb/tb_bin2bcd_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational add-3 correction applied to every digit of the BCD working register.
module bcd_digit_adj
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o
);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign bcd_o[g*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_add3(bcd_i[g*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift-add-3 step per cycle,
// start/busy/done handshake, result held between conversions.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [BIN_W-1:0]              i_bin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd
);

    localparam int CW = cnt_w(BIN_W);
    localparam int BW = BCD_DIGIT_W * DIGITS;

    if (BIN_W < 1) begin : g_bad_w
        $error("BIN_W must be at least 1");
    end
    if (10 ** DIGITS <= 2 ** BIN_W - 1) begin : g_bad_d
        $error("DIGITS too small to represent 2**BIN_W-1");
    end

    bcd_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BW-1:0]     work_q, work_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     adj;
    logic [BW+BIN_W-1:0] sh;

    bcd_digit_adj #(.DIGITS(DIGITS)) u_adj (
        .bcd_i (work_q),
        .bcd_o (adj)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        sh      = {adj, bin_q} << 1;
        if (state_q == SHIFT) begin
            {work_d, bin_d} = sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                bcd_d   = sh[BW+BIN_W-1:BIN_W];
            end
        end else if (i_start) begin
            // DONE accepts like IDLE so held-high start gives back-to-back conversions
            bin_d   = i_bin;
            work_d  = '0;
            cnt_d   = CW'(BIN_W);
            state_d = SHIFT;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
        end
    end

    assign o_busy = (state_q == SHIFT);
    assign o_done = (state_q == DONE);
    assign o_bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: vector table, full sweep, random values and handshake corner cases for bin2bcd_seq.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_bin = '0;
    logic        o_busy, o_done;
    logic [11:0] o_bcd;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] last_exp = '0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs[8];

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_conv(input logic [7:0] v, input logic [11:0] exp);
        int n;
        @(negedge clk);
        i_start = 1'b1;
        i_bin = v;
        @(negedge clk);
        i_start = 1'b0;
        i_bin = 8'($urandom);
        n = 1;
        while (!o_done && n < 20) begin
            check("busy_in_shift", 32'(o_busy), 1);
            check("hold_prev", 32'(o_bcd), 32'(last_exp));
            @(negedge clk);
            n++;
        end
        check("latency", n, 9);
        check("result", 32'(o_bcd), 32'(exp));
        check("busy_in_done", 32'(o_busy), 0);
        last_exp = exp;
        @(negedge clk);
        check("done_width", 32'(o_done), 0);
        check("held", 32'(o_bcd), 32'(exp));
    endtask

    initial begin
        int dones;
        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd1,   12'h001};
        vecs[5] = '{8'd9,   12'h009};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd199, 12'h199};

        #12;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_bcd", 32'(o_bcd), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].bcd);

        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), ref_bcd(v));
            for (int d = 0; d < 3; d++)
                check("digit_le9", 32'(o_bcd[d*4 +: 4] <= 4'd9), 1);
        end

        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 255));
            run_conv(8'(r), ref_bcd(r));
        end

        // start pulsed during SHIFT must be ignored
        @(negedge clk);
        i_start = 1'b1;
        i_bin = 8'd42;
        @(negedge clk);
        i_start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 20; n++) begin
            check("ign_busy", 32'(o_busy), 32'(n <= 8));
            if (o_done) begin
                dones++;
                check("ign_done_at", n, 9);
                check("ign_result", 32'(o_bcd), 32'h042);
            end
            i_start = (n == 3);
            i_bin = (n == 3) ? 8'd7 : 8'd0;
            @(negedge clk);
        end
        check("ign_done_count", dones, 1);
        last_exp = 12'h042;

        // held start: back-to-back conversions every 9 cycles
        i_start = 1'b1;
        i_bin = 8'd200;
        @(negedge clk);
        i_bin = 8'd13;
        for (int n = 1; n <= 18; n++) begin
            check("b2b_busy", 32'(o_busy), 32'(!(n == 9 || n == 18)));
            check("b2b_done", 32'(o_done), 32'(n == 9 || n == 18));
            if (n == 9)  check("b2b_res1", 32'(o_bcd), 32'h200);
            if (n == 18) check("b2b_res2", 32'(o_bcd), 32'h013);
            if (n == 18) i_start = 1'b0;
            if (n != 18) @(negedge clk);
        end
        @(negedge clk);
        check("b2b_idle", 32'(o_busy), 0);
        last_exp = 12'h013;

        // asynchronous reset in the middle of a conversion
        i_start = 1'b1;
        i_bin = 8'd128;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_done", 32'(o_done), 0);
        check("mid_rst_bcd", 32'(o_bcd), 0);
        repeat (2) @(negedge clk);
        check("mid_rst_hold_done", 32'(o_done), 0);
        rst_n = 1'b1;
        last_exp = '0;
        run_conv(8'd5, 12'h005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
